// File: rtl/hd_pkg.sv
// Shared decode constants and latency classes for the ID-stage hazard scoreboard.
package hd_pkg;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct7 that selects the M-extension inside OP_OP
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Result latency class of the instruction in ID
  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_LOAD,
    LAT_MUL,
    LAT_DIV
  } lat_class_e;

endpackage

// File: rtl/hd_decode.sv
// Combinational register-usage decode for the hazard scoreboard.
// Optional feature macro: HD_MULDIV_EN (MUL/DIV latency classes).
module hd_decode
  import hd_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_rd_rs1,
  output logic        o_rd_rs2,
  output logic        o_wr_rd,
  output lat_class_e  o_lat
);

  logic [6:0] w_opcode;
  logic       w_reads_rs1;
  logic       w_reads_rs2;
  logic       w_writes_rd;
  logic       w_unused_bits;

  assign w_opcode = i_inst[6:0];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign o_rd     = i_inst[11:7];

  // Immediate/funct fields only matter for the M-extension split
  assign w_unused_bits = ^{i_inst[31:25], i_inst[14:12]};

  // Classify which register fields the opcode actually uses and its latency
  always_comb begin
    w_reads_rs1 = 1'b0;
    w_reads_rs2 = 1'b0;
    w_writes_rd = 1'b0;
    o_lat       = LAT_NONE;
    case (w_opcode)
      OP_OP: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
        w_writes_rd = 1'b1;
`ifdef HD_MULDIV_EN
        if (i_inst[31:25] == FUNCT7_MULDIV) begin
          o_lat = i_inst[14] ? LAT_DIV : LAT_MUL;
        end
`else
        o_lat = LAT_NONE;
`endif
      end
      OP_IMM: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
      end
      OP_LOAD: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
        o_lat       = LAT_LOAD;
      end
      OP_STORE, OP_BRANCH: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
      end
      OP_JALR: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        w_writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is hardwired, so it never creates a dependency
  assign o_rd_rs1 = w_reads_rs1 & (o_rs1 != 5'd0);
  assign o_rd_rs2 = w_reads_rs2 & (o_rs2 != 5'd0);
  assign o_wr_rd  = w_writes_rd & (o_rd  != 5'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: one bubble countdown per architectural register.
// Optional feature macro: HD_MULDIV_EN (tracks MUL/DIV result latency).
module hazard_scoreboard
  import hd_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] inst_ID_i,
  input  logic        id_valid_i,
  input  logic        flush_i,
  output logic        ID_EX_flush,
  output logic        IF_ID_flush,
  output logic        pc_en,
  output logic        IF_ID_en,
  output logic        busy_o
);

  localparam int MAX_LM  = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_LM > DIV_LAT) ? MAX_LM : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic             w_rd_rs1;
  logic             w_rd_rs2;
  logic             w_wr_rd;
  lat_class_e       w_lat;
  logic [CNT_W-1:0] w_set_val;
  logic             w_stall;
  logic             w_issue;
  logic             w_busy;

  // Bubbles still owed to a reader of each register; entry 0 stays zero
  logic [CNT_W-1:0] r_cnt [NUM_REGS];

  hd_decode u_decode (
    .i_inst   (inst_ID_i),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd),
    .o_rd_rs1 (w_rd_rs1),
    .o_rd_rs2 (w_rd_rs2),
    .o_wr_rd  (w_wr_rd),
    .o_lat    (w_lat)
  );

  // Countdown loaded for the destination of an issuing instruction
  always_comb begin
    w_set_val = '0;
    case (w_lat)
      LAT_LOAD: w_set_val = CNT_W'(LOAD_LAT);
      LAT_MUL:  w_set_val = CNT_W'(MUL_LAT);
      LAT_DIV:  w_set_val = CNT_W'(DIV_LAT);
      default:  w_set_val = '0;
    endcase
  end

  // RAW on either source, or WAW against a still-pending older write
  assign w_stall = id_valid_i & ~flush_i &
                   ((w_rd_rs1 & (r_cnt[w_rs1] != '0)) |
                    (w_rd_rs2 & (r_cnt[w_rs2] != '0)) |
                    (w_wr_rd  & (r_cnt[w_rd]  != '0)));

  assign w_issue = id_valid_i & ~w_stall & ~flush_i;

  // Any register still owed bubbles
  always_comb begin
    w_busy = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  // Decrement every live countdown; an issuing write reloads its destination
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_issue && w_wr_rd && (int'(w_rd) == i)) begin
          r_cnt[i] <= w_set_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign ID_EX_flush = w_stall | flush_i;
  assign IF_ID_flush = flush_i;
  assign pc_en       = ~w_stall;
  assign IF_ID_en    = ~w_stall;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1 and LOAD_LAT=3) share
// one stimulus stream; a cycle-timestamp model predicts every output each cycle.
module tb_hazard_scoreboard;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  localparam logic [31:0] I_LW5  = 32'h0400A283; // lw  x5,0x40(x1)
  localparam logic [31:0] I_SUB  = 32'h401284B3; // sub x9,x5,x1
  localparam logic [31:0] I_LW1  = 32'h00002083; // lw  x1,0(x0)
  localparam logic [31:0] I_LW2  = 32'h00402103; // lw  x2,4(x0)
  localparam logic [31:0] I_ADD3 = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_DIV  = 32'h027342B3; // div x5,x6,x7
  localparam logic [31:0] I_ADD8 = 32'h00028433; // add x8,x5,x0

`ifdef HD_MULDIV_EN
  localparam int EXP_DIV_STALLS = DIV_LAT;
`else
  localparam int EXP_DIV_STALLS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] inst  = 32'h0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  logic id_ex1, ifid_fl1, pc1, ifen1, busy1;
  logic id_ex3, ifid_fl3, pc3, ifen3, busy3;

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_l1 (
    .clk(clk), .rst_i(rst_i), .inst_ID_i(inst), .id_valid_i(valid), .flush_i(flush),
    .ID_EX_flush(id_ex1), .IF_ID_flush(ifid_fl1), .pc_en(pc1), .IF_ID_en(ifen1), .busy_o(busy1)
  );

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_l3 (
    .clk(clk), .rst_i(rst_i), .inst_ID_i(inst), .id_valid_i(valid), .flush_i(flush),
    .ID_EX_flush(id_ex3), .IF_ID_flush(ifid_fl3), .pc_en(pc3), .IF_ID_en(ifen3), .busy_o(busy3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // avail[r] = first cycle index in which a reader of r may leave ID.
  typedef int avail_t [32];
  avail_t avail1;
  avail_t avail3;
  int     cyc = 0;

  initial begin
    for (int r = 0; r < 32; r++) begin
      avail1[r] = 0;
      avail3[r] = 0;
    end
  end

  // cls: 0 none, 1 load, 2 mul, 3 div
  function automatic void dec(input logic [31:0] i, output bit r1, output bit r2, output bit w,
                              output int a, output int b, output int d, output int cls);
    logic [6:0] op;
    op  = i[6:0];
    a   = int'(i[19:15]);
    b   = int'(i[24:20]);
    d   = int'(i[11:7]);
    r1  = (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) && (a != 0);
    r2  = (op inside {7'h33, 7'h23, 7'h63}) && (b != 0);
    w   = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (d != 0);
    cls = (op == 7'h03) ? 1 : 0;
`ifdef HD_MULDIV_EN
    if (op == 7'h33 && i[31:25] == 7'd1) cls = i[14] ? 3 : 2;
`endif
  endfunction

  function automatic int lat_of(input int cls, input int load_lat);
    case (cls)
      1: return load_lat;
      2: return MUL_LAT;
      3: return DIV_LAT;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_stall(input avail_t av);
    bit r1, r2, w;
    int a, b, d, cls;
    dec(inst, r1, r2, w, a, b, d, cls);
    if (!valid || flush) return 1'b0;
    return (r1 && cyc < av[a]) || (r2 && cyc < av[b]) || (w && cyc < av[d]);
  endfunction

  function automatic bit m_busy(input avail_t av);
    for (int r = 1; r < 32; r++) if (av[r] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  // Model state advance at each edge; reset wipes all pending results
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 32; r++) begin
        avail1[r] = 0;
        avail3[r] = 0;
      end
    end else begin
      bit s1, s3, r1, r2, w;
      int a, b, d, cls;
      s1 = m_stall(avail1);
      s3 = m_stall(avail3);
      dec(inst, r1, r2, w, a, b, d, cls);
      if (valid && !flush && w) begin
        if (!s1) avail1[d] = cyc + 1 + lat_of(cls, 1);
        if (!s3) avail3[d] = cyc + 1 + lat_of(cls, 3);
      end
      cyc++;
    end
  end

  // Per-cycle compare of every output of both instances
  always @(negedge clk) begin
    bit e1, e3;
    e1 = m_stall(avail1);
    e3 = m_stall(avail3);
    chk("l1_id_ex_flush", id_ex1,   e1 | flush);
    chk("l1_if_id_flush", ifid_fl1, flush);
    chk("l1_pc_en",       pc1,      !e1);
    chk("l1_if_id_en",    ifen1,    !e1);
    chk("l1_busy",        busy1,    m_busy(avail1));
    chk("l3_id_ex_flush", id_ex3,   e3 | flush);
    chk("l3_if_id_flush", ifid_fl3, flush);
    chk("l3_pc_en",       pc3,      !e3);
    chk("l3_if_id_en",    ifen3,    !e3);
    chk("l3_busy",        busy3,    m_busy(avail3));
  end

  // ---------------- driver tasks ----------------
  logic last_st1, last_st3, last_b3;

  // One ID cycle: called at posedge+1, returns at the next posedge+1
  task automatic step(input logic [31:0] i, input logic v, input logic f);
    inst  = i;
    valid = v;
    flush = f;
    @(negedge clk);
    last_st1 = !pc1;
    last_st3 = !pc3;
    last_b3  = busy3;
    @(posedge clk);
    #1;
  endtask

  // Hold one instruction in ID for n cycles, recording the stall pattern (bit k = cycle k)
  task automatic hold(input logic [31:0] i, input int n, output logic [63:0] p1, output logic [63:0] p3);
    p1 = '0;
    p3 = '0;
    for (int k = 0; k < n; k++) begin
      step(i, 1'b1, 1'b0);
      p1[k] = last_st1;
      p3[k] = last_st3;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'h0, 1'b0, 1'b0);
  endtask

  function automatic int popc(input logic [63:0] v);
    int c = 0;
    for (int k = 0; k < 64; k++) c += int'(v[k]);
    return c;
  endfunction

  // ---------------- directed tests ----------------
  logic [63:0] p1, p3;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_pc_en_l1", pc1, 1);
    chk("reset_pc_en_l3", pc3, 1);
    chk("reset_busy_l3",  busy3, 0);
    chk("reset_id_ex_l1", id_ex1, 0);
    @(posedge clk);
    #1;

    // 1/2: load-use, 1 bubble vs 3 consecutive bubbles
    step(I_LW5, 1'b1, 1'b0);
    chk("t1_lw_no_stall", last_st1, 0);
    for (int k = 0; k < 5; k++) begin
      step(I_SUB, 1'b1, 1'b0);
      p1[k] = last_st1;
      p3[k] = last_st3;
      if (k == 2) chk("t2_busy_last_stall", last_b3, 1);
      if (k == 3) chk("t2_busy_after",      last_b3, 0);
    end
    chk("t1_pattern", p1[4:0], 5'b00001);
    chk("t2_pattern", p3[4:0], 5'b00111);
    idle(5);

    // 3: two loads then consumer of both
    step(I_LW1, 1'b1, 1'b0);
    step(I_LW2, 1'b1, 1'b0);
    chk("t3_lw2_no_stall_l1", last_st1, 0);
    chk("t3_lw2_no_stall_l3", last_st3, 0);
    hold(I_ADD3, 5, p1, p3);
    chk("t3_pattern_l1", p1[4:0], 5'b00001);
    chk("t3_pattern_l3", p3[4:0], 5'b00111);
    idle(5);

    // 4: squashed load sets nothing
    step(I_LW5, 1'b1, 1'b1);
    hold(I_SUB, 3, p1, p3);
    chk("t4_stalls_l1", popc(p1), 0);
    chk("t4_stalls_l3", popc(p3), 0);
    idle(5);

    // 5: divide then dependent add
    step(I_DIV, 1'b1, 1'b0);
    hold(I_ADD8, DIV_LAT + 3, p1, p3);
    chk("t5_stalls_l1", popc(p1), EXP_DIV_STALLS);
    chk("t5_stalls_l3", popc(p3), EXP_DIV_STALLS);
    idle(DIV_LAT + 5);

    // 6: reset pulse mid-countdown
    step(I_LW5, 1'b1, 1'b0);
    step(I_SUB, 1'b1, 1'b0);
    chk("t6_first_stall", last_st3, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_pc_en",  pc3,   1);
    chk("t6_rst_busy",   busy3, 0);
    chk("t6_rst_busy_l1", busy1, 0);
    @(posedge clk);
    #1;
    chk("t6_rst_hold_pc_en", pc3,   1);
    chk("t6_rst_hold_busy",  busy3, 0);
    #2;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    hold(I_SUB, 3, p1, p3);
    chk("t6_after_stalls_l3", popc(p3), 0);
    chk("t6_after_stalls_l1", popc(p1), 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
